gpia_port_in: RTL and testbench

GPIA_PORT_IN -- requirements
Module: gpia_port_in

---
 rtl/gpia_pkg.sv | 18 +
 rtl/gpia_sync.sv | 36 +++
 rtl/gpia_port_in.sv | 100 ++++++++++
 tb/tb_gpia_port_in.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpia_pkg.sv
// Shared definitions for the GPIA port blocks: register select encodings,
// synchronizer depth bounds and arm counter sizing.
package gpia_pkg;

    localparam logic ADR_DATA = 1'b0;
    localparam logic ADR_PEND = 1'b1;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Wide enough to hold SYNC_STAGES_MAX + 1.
    localparam int ARM_W = 3;

    function automatic logic sync_stages_legal(input int stages);
        return (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
    endfunction

endpackage

// File: rtl/gpia_sync.sv
// Multi-flop synchronizer bringing asynchronous pin samples into the clk_i
// domain; all bits share the same depth.
module gpia_sync
    import gpia_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_stages
        $error("gpia_sync: SYNC_STAGES out of range");
    end

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= async_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpia_port_in.sv
// GPIA input port: synchronized pin readback, edge-pending register and
// interrupt. Edge/interrupt logic is built only with GPIA_PORT_IN_IRQ_EN.
module gpia_port_in
    import gpia_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] inp_i,
    input  logic [WIDTH-1:0] out_i,
    input  logic [WIDTH-1:0] ddr_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic             adr_i,
    input  logic [WIDTH-1:0] dat_i,
    input  logic [WIDTH-1:0] ien_i,
    output logic [WIDTH-1:0] dat_o,
    output logic             ack_o,
    output logic             irq_o
);

    // Bus handshake: a cycle is accepted on the edge where stb_i=1 and
    // ack_o=0; ack_o is then high for exactly one cycle, so a held stb_i
    // yields one transfer every other cycle.
    logic             bus_take;
    logic             rd_en;
    logic             wr_pend;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] pend_view;

    gpia_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .async_i (inp_i),
        .sync_o  (sync)
    );

    assign bus_take = stb_i && !ack_o;
    assign rd_en    = bus_take && !we_i;
    assign wr_pend  = bus_take && we_i && (adr_i == ADR_PEND);
    assign rb       = (ddr_i & out_i) | (~ddr_i & sync);

`ifdef GPIA_PORT_IN_IRQ_EN
    localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] pend;
    logic [ARM_W-1:0] arm_cnt;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] pend_clr;

    // Edges are ignored until the synchronizer has flushed its reset zeros.
    assign edge_set = (sync ^ prev) & ~ddr_i & {WIDTH{arm_cnt == '0}};
    assign pend_clr = wr_pend ? dat_i : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev    <= '0;
            pend    <= '0;
            arm_cnt <= ARM_LOAD;
        end else begin
            prev <= sync;
            pend <= (pend & ~pend_clr) | edge_set;
            if (arm_cnt != '0) begin
                arm_cnt <= arm_cnt - 1'b1;
            end
        end
    end

    assign pend_view = pend;
    assign irq_o     = |(pend & ien_i);
`else
    logic unused_irq_inputs;

    assign unused_irq_inputs = ^{ien_i, dat_i, wr_pend};
    assign pend_view         = '0;
    assign irq_o             = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ack_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= bus_take;
            if (rd_en) begin
                dat_o <= (adr_i == ADR_DATA) ? rb : pend_view;
            end else begin
                dat_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gpia_port_in.sv
// Self-checking bench for gpia_port_in (WIDTH=16, SYNC_STAGES=2); the edge
// and interrupt scenarios follow the GPIA_PORT_IN_IRQ_EN build setting.
module tb_gpia_port_in;

    localparam int W = 16;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         reset_i;
    logic [W-1:0] inp_i, out_i, ddr_i, dat_i, ien_i;
    logic         stb_i, we_i, adr_i;
    logic [W-1:0] dat_o;
    logic         ack_o, irq_o;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    gpia_port_in #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .inp_i   (inp_i),
        .out_i   (out_i),
        .ddr_i   (ddr_i),
        .stb_i   (stb_i),
        .we_i    (we_i),
        .adr_i   (adr_i),
        .dat_i   (dat_i),
        .ien_i   (ien_i),
        .dat_o   (dat_o),
        .ack_o   (ack_o),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    // Advance one edge and land 1 time unit after it (sample/drive point).
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_read(input logic adr, input logic [W-1:0] expected, input string name);
        logic [W-1:0] e;
        stb_i = 1'b1;
        we_i  = 1'b0;
        adr_i = adr;
        exp_q.push_back(expected);
        step();
        stb_i = 1'b0;
        checks++;
        if (ack_o !== 1'b1) begin
            errors++;
            $display("FAIL %s ack: got %b want 1", name, ack_o);
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (dat_o !== e) begin
                errors++;
                $display("FAIL %s dat_o: got %h want %h", name, dat_o, e);
            end
        end
        step();
    endtask

    task automatic bus_write(input logic adr, input logic [W-1:0] data, input string name);
        stb_i = 1'b1;
        we_i  = 1'b1;
        adr_i = adr;
        dat_i = data;
        step();
        stb_i = 1'b0;
        we_i  = 1'b0;
        checks++;
        if (ack_o !== 1'b1) begin
            errors++;
            $display("FAIL %s ack: got %b want 1", name, ack_o);
        end
        checks++;
        if (dat_o !== '0) begin
            errors++;
            $display("FAIL %s write dat_o: got %h want 0000", name, dat_o);
        end
        step();
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        stb_i   = 1'b1;
        inp_i   = 16'hFFFF;
        step(3);
        checks++;
        if (ack_o !== 1'b0 || dat_o !== '0 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ack=%b dat=%h irq=%b want 0/0000/0", ack_o, dat_o, irq_o);
        end
        stb_i   = 1'b0;
        reset_i = 1'b0;
        step(6);
        // Inputs were high through reset; the arm window must hide that edge.
        bus_read(1'b1, 16'h0000, "reset_pend_suppressed");
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b want 0", irq_o);
        end
    endtask

    task automatic test_readback();
        logic [W-1:0] d, o, p;
        ddr_i = 16'hFF00;
        out_i = 16'hAB00;
        inp_i = 16'h00CD;
        step(4);
        bus_read(1'b0, 16'hABCD, "readback_fixed");
        for (int i = 0; i < 4; i++) begin
            d = W'($urandom_range(0, 16'hFFFF));
            o = W'($urandom_range(0, 16'hFFFF));
            p = W'($urandom_range(0, 16'hFFFF));
            ddr_i = d;
            out_i = o;
            inp_i = p;
            step(4);
            bus_read(1'b0, (d & o) | (~d & p), "readback_random");
        end
    endtask

    task automatic test_sync_latency();
        ddr_i = 16'h0000;
        inp_i = 16'h0000;
        step(4);
        inp_i = 16'h5A5A;
        step(S - 1);
        bus_read(1'b0, 16'h0000, "sync_not_yet");
        inp_i = 16'hA5A5;
        step(S);
        bus_read(1'b0, 16'hA5A5, "sync_arrived");
    endtask

    task automatic test_ack_pattern();
        logic model_ack = 1'b0;
        logic [W-1:0] e;
        ddr_i = 16'hFFFF;
        out_i = 16'h1234;
        stb_i = 1'b1;
        we_i  = 1'b0;
        adr_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                if (!model_ack) exp_q.push_back(16'h1234);
                model_ack = !model_ack;
                step();
            end
            checks++;
            if (ack_o !== model_ack) begin
                errors++;
                $display("FAIL ack_pattern[%0d]: got %b want %b", k, ack_o, model_ack);
            end
            e = model_ack ? exp_q.pop_front() : '0;
            checks++;
            if (dat_o !== e) begin
                errors++;
                $display("FAIL ack_pattern_dat[%0d]: got %h want %h", k, dat_o, e);
            end
        end
        stb_i = 1'b0;
        step(2);
    endtask

    task automatic test_data_write();
        ddr_i = 16'hFFFF;
        out_i = 16'h0F0F;
        bus_write(1'b0, 16'hFFFF, "data_write");
        bus_read(1'b0, 16'h0F0F, "data_write_no_effect");
    endtask

`ifdef GPIA_PORT_IN_IRQ_EN
    task automatic test_edge_irq();
        ddr_i = 16'h0000;
        ien_i = 16'h0008;
        inp_i = 16'h0000;
        step(4);
        bus_write(1'b1, 16'hFFFF, "pend_clear_all");
        bus_read(1'b1, 16'h0000, "pend_cleared");
        inp_i = 16'h0008;
        for (int k = 1; k <= S + 1; k++) begin
            step();
            checks++;
            if (irq_o !== (k == S + 1)) begin
                errors++;
                $display("FAIL edge_irq_latency[%0d]: got %b want %b", k, irq_o, k == S + 1);
            end
        end
        bus_read(1'b1, 16'h0008, "edge_pend_set");
        // Falling edge on bit 3 lands on the same edge as the clearing write.
        inp_i = 16'h0000;
        step(S);
        bus_write(1'b1, 16'h0008, "clear_vs_set");
        bus_read(1'b1, 16'h0008, "set_wins");
        bus_write(1'b1, 16'h0008, "clear_again");
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_after_clear: got %b want 0", irq_o);
        end
        bus_read(1'b1, 16'h0000, "pend_after_clear");
        inp_i = 16'h0008;
        step(S + 2);
        ddr_i = 16'h0008;
        step(2);
        bus_read(1'b1, 16'h0008, "ddr_keeps_pend");
    endtask
`else
    task automatic test_irq_disabled();
        ddr_i = 16'h0000;
        ien_i = 16'hFFFF;
        inp_i = 16'h0000;
        step(4);
        inp_i = 16'h0008;
        for (int k = 1; k <= S + 2; k++) begin
            step();
            checks++;
            if (irq_o !== 1'b0) begin
                errors++;
                $display("FAIL irq_disabled[%0d]: got %b want 0", k, irq_o);
            end
        end
        bus_read(1'b1, 16'h0000, "pend_read_disabled");
        bus_write(1'b1, 16'hFFFF, "pend_write_disabled");
        bus_read(1'b0, 16'h0008, "data_after_pend_write");
    endtask
`endif

    initial begin
        inp_i = '0; out_i = '0; ddr_i = '0; dat_i = '0; ien_i = '0;
        stb_i = 1'b0; we_i = 1'b0; adr_i = 1'b0; reset_i = 1'b1;
        test_reset();
        test_readback();
        test_sync_latency();
        test_ack_pattern();
        test_data_write();
`ifdef GPIA_PORT_IN_IRQ_EN
        test_edge_irq();
`else
        test_irq_disabled();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
